// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the insertion sorter and its drain stage.
package sort_pkg;

    localparam int SORT_N  = 64;
    localparam int SORT_W  = 8;
    localparam int SORT_LW = $clog2(SORT_N + 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

endpackage

// File: rtl/sorted_drain_snapshot_ram.sv
// N x 2W snapshot register file: wide parallel write, one indexed read port.
module snapshot_ram #(
    parameter int N  = sort_pkg::SORT_N,
    parameter int W  = sort_pkg::SORT_W,
    parameter int LW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [N*W-1:0]  wr_data,
    input  logic [N*W-1:0]  wr_addr,
    input  logic [LW-1:0]   rd_idx,
    output logic [W-1:0]    rd_data,
    output logic [W-1:0]    rd_addr
);

    logic [2*W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= {wr_data[W*i +: W], wr_addr[W*i +: W]};
            end
        end
    end

    // Out-of-range index (one past the final entry) reads as zero.
    always_comb begin
        rd_data = '0;
        rd_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_idx == LW'(i)) begin
                rd_data = mem[i][2*W-1:W];
                rd_addr = mem[i][W-1:0];
            end
        end
    end

endmodule

// File: rtl/sorted_drain.sv
// Snapshots the sorter output buses and streams the first len entries, largest first.
module sorted_drain #(
    parameter int N  = sort_pkg::SORT_N,
    parameter int W  = sort_pkg::SORT_W,
    parameter int LW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [LW-1:0]   len,
    input  logic [N*W-1:0]  sorted_data,
    input  logic [N*W-1:0]  sorted_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [W-1:0]    out_addr,
    output logic [LW-1:0]   out_index,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    import sort_pkg::*;

    localparam logic [LW-1:0] N_L = LW'(N);
    localparam logic [LW-1:0] ONE = LW'(1);

    state_t         state;
    state_t         state_next;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  cnt_new;
    logic [LW-1:0]  idx_next;
    logic           hs;
    logic           wr_en;
    logic           done_next;
    logic           ovr_set;
    logic [W-1:0]   rd_data;
    logic [W-1:0]   rd_addr;

    assign busy      = (state == S_STREAM);
    assign out_valid = busy;
    assign hs        = out_valid && out_ready;
    assign cnt_new   = (len > N_L) ? N_L : len;
    assign idx_next  = out_index + ONE;

    snapshot_ram #(
        .N  (N),
        .W  (W),
        .LW (LW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_data (sorted_data),
        .wr_addr (sorted_addr),
        .rd_idx  (idx_next),
        .rd_data (rd_data),
        .rd_addr (rd_addr)
    );

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        done_next  = 1'b0;
        ovr_set    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (capture) begin
                    wr_en = 1'b1;
                    if (cnt_new != '0) begin
                        state_next = S_STREAM;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (hs && out_last) begin
                    done_next = 1'b1;
                    // A capture on the final beat chains straight into the next drain.
                    if (capture) begin
                        wr_en      = 1'b1;
                        state_next = (cnt_new != '0) ? S_STREAM : S_IDLE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (capture) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Entry 0 comes straight from the live bus so it is visible one edge after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_index <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (ovr_set) begin
                overrun <= 1'b1;
            end
            if (wr_en) begin
                cnt       <= cnt_new;
                out_index <= '0;
                out_data  <= sorted_data[W-1:0];
                out_addr  <= sorted_addr[W-1:0];
                out_last  <= (cnt_new == ONE);
            end else if (hs) begin
                out_index <= idx_next;
                out_data  <= rd_data;
                out_addr  <= rd_addr;
                out_last  <= (idx_next == cnt - ONE);
            end
        end
    end

endmodule

// File: doc/sorted_drain.md
# sorted_drain

Downstream stage of the systolic insertion sorter. On a capture pulse it snapshots the sorter's flattened `sorted_data`/`sorted_addr` buses. It then streams the first `len` entries out one per handshake, as (data, addr) pairs in index order 0 first. Index 0 holds the largest value, so the output order is non-increasing. This frees the sorter for reset and reload while the previous result drains.

## Interface
- `N`, 64: number of sorter entries; must match the sorter instance.
- `W`, 8: element and address width.
- `LW`, `$clog2(N+1)`: width of `len` and of the index counter.

- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `capture` input 1: single-cycle pulse; the sorter buses are valid and final in this cycle.
- `len` input LW: number of entries to emit, sampled with `capture`; values > N clamp to N.
- `sorted_data` input N*W: sorter data bus; entry i is at `[W*i+W-1 : W*i]`.
- `sorted_addr` input N*W: sorter address bus, same packing.
- `out_valid` output 1: `out_data`/`out_addr` hold a valid element.
- `out_ready` input 1: sink accepts; a beat transfers when `out_valid && out_ready`.
- `out_data` output W: element value.
- `out_addr` output W: element's original address.
- `out_index` output LW: rank of the current element (0 = largest).
- `out_last` output 1: current element is the final one of this drain.
- `busy` output 1: a drain is in progress.
- `done` output 1: one-cycle pulse after a drain completes.
- `overrun` output 1: sticky; set when `capture` is refused. Cleared only by `rst`.

## Operation
- Two states: IDLE and STREAM.
- **Capture:** in IDLE, `capture` copies both buses into internal N-entry register arrays and latches `min(len, N)` as `cnt`.
  - If `cnt > 0`: go to STREAM with index = 0.
  - If `cnt == 0`: stay in IDLE and pulse `done` the next cycle; no beats are emitted.
- **STREAM:**
  - `out_data`/`out_addr` show snapshot entry `index`.
  - `out_valid` stays 1 until the handshake; the payload is held stable while `out_ready` is 0.
  - Each handshake increments `index`.
  - `out_last = (index == cnt-1)`.
  - A handshake on the last beat returns to IDLE and pulses `done`.
- **Capture while busy:** `capture` in STREAM is refused, except in the cycle of the final handshake. The snapshot is untouched and `overrun` is set.
- **Final-handshake capture:** a `capture` in the same cycle as the final handshake is accepted. The FSM stays in STREAM with index 0 and the new snapshot, giving back-to-back drains. `done` still pulses for the completed drain.
- **Snapshot isolation:** the snapshot is independent of the live buses after capture, so the sorter may reset or reload mid-drain.

## Timing
- **Reset values:** state IDLE; `out_valid`, `busy`, `done`, `overrun`, `out_last` = 0; `out_index` = 0; `out_data`/`out_addr` = 0. Snapshot arrays are not reset.
- **Reset mid-drain:** `rst` aborts the drain. Outputs take reset values next cycle, no `done` pulse is produced, and the partial beat is dropped.
- **Latency:** `capture` at edge T gives `out_valid` = 1 with entry 0 after edge T+1.
- **Throughput:** one beat per cycle with `out_ready` held 1. A drain of `cnt` entries takes `cnt` cycles of `out_valid`.
- **Output timing:** all outputs are registered; no combinational path from `out_ready` to `out_valid`.
- **`busy`:** equals (state == STREAM).
- **`done`:** asserted the cycle after the final handshake, exactly 1 cycle wide.

## Structure
- Shared package `sort_pkg` holds `N`, `W`, `LW` defaults and the state enum `{S_IDLE, S_STREAM}`. The sorter instance uses the same constants.
- Optional sub-module `snapshot_ram`: N x 2W register file with a wide parallel write and an indexed read port. The FSM, counter and flags stay in `sorted_drain`.

## Test plan
- **Full drain:** N=4, buses data {9,7,7,2} / addr {3,0,2,1}, `len`=4, `out_ready`=1. Expect 4 consecutive beats (9,3),(7,0),(7,2),(2,1); `out_last` on beat 3; `done` one cycle later.
- **Backpressure:** same stimulus, `out_ready` toggling 1,0,0,1,... Expect payload held while stalled, no duplicated or lost beats, index sequence 0..3.
- **Length edge cases:** `len`=0 gives no `out_valid` and `done` one cycle after capture. `len`=9 with N=4 clamps to 4 beats.
- **Overrun:** `capture` at beat 1 of a 4-beat drain. Expect the stream unchanged and `overrun`=1 until `rst`.
- **Back-to-back:** `capture` coincident with the final handshake. Expect the next cycle to show new entry 0 with `out_valid`=1 and one `done` pulse.
- **Abort:** `rst` asserted during beat 2. Expect all outputs at reset values next cycle, no `done`, and a fresh capture working normally afterward.
